// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the 16-bit processor: fetches from a synchronous ROM,
// decodes and sequences register file, ALU and data-memory controls.
module multicycle_ctrl #(
  parameter int PC_W     = 7,
  parameter int RESET_PC = 0,
  parameter int D_AW     = 8,
  parameter bit DMEM_HS  = 1'b1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Run,
  input  logic            Step,
  output logic [PC_W-1:0] IM_Addr,
  output logic            IM_Rd,
  input  logic [15:0]     IM_Data,
  output logic [D_AW-1:0] D_Addr,
  output logic            D_Rd,
  output logic            D_Wr,
  input  logic            D_Ack,
  output logic            RF_s,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [3:0]      RF_W_Addr,
  output logic [2:0]      ALU_s0,
  output logic [15:0]     IR_Out,
  output logic [PC_W-1:0] PC_Out,
  output logic [3:0]      State,
  output logic [3:0]      NextState,
  output logic            Halted,
  output logic            Illegal
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              illegal_q, illegal_d;
  logic              mem_done;

  // Without the handshake a memory access always completes in one cycle.
  assign mem_done = (DMEM_HS == 1'b0) || D_Ack;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: if (Run || Step) state_d = S_DECODE;
      S_DECODE: begin
        // The ROM word arrives this cycle; decode it directly rather than waiting for IR.
        ir_d = IM_Data;
        pc_d = pc_q + PC_W'(1);
        case (IM_Data[15:12])
          4'h0: state_d = S_NOOP;
          4'h1: state_d = S_STORE;
          4'h2: state_d = S_LOAD_A;
          4'h3: state_d = S_ADD;
          4'h4: state_d = S_SUB;
          4'h5: state_d = S_HALT;
          default: begin
            state_d   = S_NOOP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_LOAD_A: if (mem_done) state_d = S_LOAD_B;
      S_STORE:  if (mem_done) state_d = S_FETCH;
      S_LOAD_B, S_NOOP, S_ADD, S_SUB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
    if (!Reset) state_d = S_INIT;
  end

  // NOTE: reset is synchronous here: it is sampled only on the rising clock edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= S_INIT;
      pc_q      <= PC_W'(RESET_PC);
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    IM_Rd      = 1'b0;
    D_Addr     = '0;
    D_Rd       = 1'b0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = 4'd0;
    RF_Rb_Addr = 4'd0;
    RF_W_Addr  = 4'd0;
    ALU_s0     = 3'd0;
    Halted     = 1'b0;
    case (state_q)
      S_FETCH: IM_Rd = 1'b1;
      S_LOAD_A: begin
        D_Addr = ir_q[D_AW-1:0];
        D_Rd   = 1'b1;
      end
      S_LOAD_B: begin
        D_Addr    = ir_q[D_AW-1:0];
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
        RF_W_Addr = ir_q[11:8];
      end
      S_STORE: begin
        D_Addr     = ir_q[4 +: D_AW];
        RF_Ra_Addr = ir_q[3:0];
        D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = ir_q[11:8];
        RF_Rb_Addr = ir_q[7:4];
        RF_W_Addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
    // Side-effecting strobes must drop in the very cycle reset is asserted.
    if (!Reset) begin
      D_Rd    = 1'b0;
      D_Wr    = 1'b0;
      RF_W_en = 1'b0;
    end
  end

  assign IM_Addr   = pc_q;
  assign PC_Out    = pc_q;
  assign IR_Out    = ir_q;
  assign State     = state_q;
  assign NextState = state_d;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: two instances (handshake on / off, different
// widths) run directed programs and random stimulus against an instruction-level model.
module tb_multicycle_ctrl;

  localparam int S_INIT = 0, S_FETCH = 1, S_DECODE = 2, S_NOOP = 3, S_LOAD_A = 4,
                 S_LOAD_B = 5, S_STORE = 6, S_ADD = 7, S_SUB = 8, S_HALT = 9;
  localparam int OP_STATE [6] = '{S_NOOP, S_STORE, S_LOAD_A, S_ADD, S_SUB, S_HALT};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, run = 1'b0, step = 1'b0, d_ack = 1'b0;

  logic [6:0]  a_im_addr, a_pc;
  logic [15:0] a_im_data, a_ir;
  logic [7:0]  a_d_addr;
  logic        a_im_rd, a_d_rd, a_d_wr, a_rf_s, a_rf_we, a_halted, a_illegal;
  logic [3:0]  a_ra, a_rb, a_wa, a_state, a_next;
  logic [2:0]  a_alu;

  logic [4:0]  b_im_addr, b_pc;
  logic [15:0] b_im_data, b_ir;
  logic [3:0]  b_d_addr;
  logic        b_im_rd, b_d_rd, b_d_wr, b_rf_s, b_rf_we, b_halted, b_illegal;
  logic [3:0]  b_ra, b_rb, b_wa, b_state, b_next;
  logic [2:0]  b_alu;

  multicycle_ctrl #(.PC_W(7), .RESET_PC(0), .D_AW(8), .DMEM_HS(1'b1)) u_a (
    .Clk(clk), .Reset(rst_n), .Run(run), .Step(step),
    .IM_Addr(a_im_addr), .IM_Rd(a_im_rd), .IM_Data(a_im_data),
    .D_Addr(a_d_addr), .D_Rd(a_d_rd), .D_Wr(a_d_wr), .D_Ack(d_ack),
    .RF_s(a_rf_s), .RF_W_en(a_rf_we), .RF_Ra_Addr(a_ra), .RF_Rb_Addr(a_rb),
    .RF_W_Addr(a_wa), .ALU_s0(a_alu), .IR_Out(a_ir), .PC_Out(a_pc),
    .State(a_state), .NextState(a_next), .Halted(a_halted), .Illegal(a_illegal)
  );

  multicycle_ctrl #(.PC_W(5), .RESET_PC(0), .D_AW(4), .DMEM_HS(1'b0)) u_b (
    .Clk(clk), .Reset(rst_n), .Run(run), .Step(step),
    .IM_Addr(b_im_addr), .IM_Rd(b_im_rd), .IM_Data(b_im_data),
    .D_Addr(b_d_addr), .D_Rd(b_d_rd), .D_Wr(b_d_wr), .D_Ack(d_ack),
    .RF_s(b_rf_s), .RF_W_en(b_rf_we), .RF_Ra_Addr(b_ra), .RF_Rb_Addr(b_rb),
    .RF_W_Addr(b_wa), .ALU_s0(b_alu), .IR_Out(b_ir), .PC_Out(b_pc),
    .State(b_state), .NextState(b_next), .Halted(b_halted), .Illegal(b_illegal)
  );

  // Synchronous ROM shared by both instances, one-cycle read latency.
  logic [15:0] rom [256];
  always @(posedge clk) if (a_im_rd) a_im_data <= rom[{1'b0, a_im_addr}];
  always @(posedge clk) if (b_im_rd) b_im_data <= rom[{3'b0, b_im_addr}];

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction-level reference: where the unit is, what it holds.
  typedef struct {
    int          st;
    int          pc;
    logic [15:0] ir;
    bit          ill;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step_m(mdl_t m, bit r, bit rn, bit sp, bit ak, bit hs, int pcw, int rpc);
    mdl_t n = m;
    int op;
    if (!r) begin
      n.st = S_INIT; n.pc = rpc; n.ir = '0; n.ill = 1'b0;
      return n;
    end
    case (m.st)
      S_INIT:   n.st = S_FETCH;
      S_FETCH:  if (rn || sp) n.st = S_DECODE;
      S_DECODE: begin
        n.ir = rom[m.pc];
        n.pc = (m.pc + 1) % (1 << pcw);
        op   = int'(n.ir[15:12]);
        if (op < 6) n.st = OP_STATE[op];
        else begin n.st = S_NOOP; n.ill = 1'b1; end
      end
      S_LOAD_A: if (!hs || ak) n.st = S_LOAD_B;
      S_STORE:  if (!hs || ak) n.st = S_FETCH;
      S_LOAD_B, S_NOOP, S_ADD, S_SUB: n.st = S_FETCH;
      default: ;
    endcase
    return n;
  endfunction

  // {im_rd, d_rd, d_wr, rf_w_en, rf_s, halted}
  function automatic logic [31:0] exp_flags(mdl_t m, bit r);
    bit im_rd, d_rd, d_wr, we, rfs, hlt;
    im_rd = (m.st == S_FETCH);
    d_rd  = (m.st == S_LOAD_A) && r;
    d_wr  = (m.st == S_STORE) && r;
    we    = (m.st == S_LOAD_B || m.st == S_ADD || m.st == S_SUB) && r;
    rfs   = (m.st == S_LOAD_B);
    hlt   = (m.st == S_HALT);
    return {26'd0, im_rd, d_rd, d_wr, we, rfs, hlt};
  endfunction

  // {d_addr[7:0], ra, rb, wa, alu}
  function automatic logic [31:0] exp_addr(mdl_t m, int daw);
    int da = 0, ra = 0, rb = 0, wa = 0, alu = 0;
    int mask = (1 << daw) - 1;
    int ir = int'(m.ir);
    case (m.st)
      S_LOAD_A: da = ir & mask;
      S_LOAD_B: begin da = ir & mask; wa = (ir >> 8) & 15; end
      S_STORE:  begin da = (ir >> 4) & mask; ra = ir & 15; end
      S_ADD, S_SUB: begin
        ra = (ir >> 8) & 15; rb = (ir >> 4) & 15; wa = ir & 15;
        alu = (m.st == S_ADD) ? 1 : 2;
      end
      default: ;
    endcase
    return 32'((da << 15) | (ra << 11) | (rb << 7) | (wa << 3) | alu);
  endfunction

  // Values seen at the most recent compare point.
  logic [31:0] oa_state, oa_pc, oa_ir, oa_daddr, oa_ra, oa_rb, oa_wa, oa_alu;
  logic        oa_dwr, oa_halt, oa_ill, oa_rfs, ob_ill;
  logic [31:0] ob_state;
  bit          started = 1'b0;

  task automatic tick(input bit r, input bit rn, input bit sp, input bit ak, input bit chk);
    mdl_t nxa, nxb;
    @(negedge clk);
    rst_n = r; run = rn; step = sp; d_ack = ak;
    #1;
    oa_state = 32'(a_state); oa_pc = 32'(a_pc); oa_ir = 32'(a_ir);
    oa_daddr = 32'(a_d_addr); oa_ra = 32'(a_ra); oa_rb = 32'(a_rb);
    oa_wa = 32'(a_wa); oa_alu = 32'(a_alu); oa_dwr = a_d_wr; oa_halt = a_halted;
    oa_ill = a_illegal; oa_rfs = a_rf_s; ob_state = 32'(b_state); ob_ill = b_illegal;
    if (chk) begin
      nxa = step_m(ma, r, rn, sp, ak, 1'b1, 7, 0);
      nxb = step_m(mb, r, rn, sp, ak, 1'b0, 5, 0);
      check("a.state", 32'(a_state), 32'(ma.st));
      check("a.next", 32'(a_next), 32'(nxa.st));
      check("a.pc", 32'(a_pc), 32'(ma.pc));
      check("a.im_addr", 32'(a_im_addr), 32'(ma.pc));
      check("a.ir", 32'(a_ir), 32'(ma.ir));
      check("a.illegal", 32'(a_illegal), 32'(ma.ill));
      check("a.flags", {26'd0, a_im_rd, a_d_rd, a_d_wr, a_rf_we, a_rf_s, a_halted}, exp_flags(ma, r));
      check("a.addr", {9'd0, a_d_addr, a_ra, a_rb, a_wa, a_alu}, exp_addr(ma, 8));
      check("b.state", 32'(b_state), 32'(mb.st));
      check("b.next", 32'(b_next), 32'(nxb.st));
      check("b.pc", 32'(b_pc), 32'(mb.pc));
      check("b.im_addr", 32'(b_im_addr), 32'(mb.pc));
      check("b.ir", 32'(b_ir), 32'(mb.ir));
      check("b.illegal", 32'(b_illegal), 32'(mb.ill));
      check("b.flags", {26'd0, b_im_rd, b_d_rd, b_d_wr, b_rf_we, b_rf_s, b_halted}, exp_flags(mb, r));
      check("b.addr", {13'd0, b_d_addr, b_ra, b_rb, b_wa, b_alu}, exp_addr(mb, 4));
    end
    @(posedge clk);
    ma = step_m(ma, r, rn, sp, ak, 1'b1, 7, 0);
    mb = step_m(mb, r, rn, sp, ak, 1'b0, 5, 0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1, 1'b0, 1'b0, started);
    started = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic fill_rom_random(input bit allow_all);
    for (int i = 0; i < 256; i++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 99);
      if (!allow_all)  op = 4'($urandom_range(0, 4));
      else if (r < 2)  op = 4'd5;
      else if (r < 10) op = 4'($urandom_range(6, 15));
      else             op = 4'($urandom_range(0, 4));
      rom[i] = {op, 12'($urandom)};
    end
  endtask

  initial begin
    int exp_seq [5] = '{S_INIT, S_FETCH, S_DECODE, S_NOOP, S_FETCH};
    int seen, st_cnt_a, st_cnt_b, wr_cnt_a, na;
    bit saw_ill_noop, saw_wrap;
    logic [31:0] prev_pc;

    // Reset and basic sequencing
    clear_rom();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("seq.state", oa_state, 32'(exp_seq[i]));
      if (i == 1) check("seq.pc_first_fetch", oa_pc, 32'd0);
      if (i == 4) check("seq.pc_second_fetch", oa_pc, 32'd1);
    end

    // LOAD / ADD / STORE / HALT program
    clear_rom();
    rom[0] = 16'h221B; rom[1] = 16'h3243; rom[2] = 16'h1A53; rom[3] = 16'h5000;
    do_reset();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      if (oa_state == 32'(S_LOAD_B)) begin
        seen |= 1;
        check("prog.loadb_wa", oa_wa, 32'd2);
        check("prog.loadb_rfs", 32'(oa_rfs), 32'd1);
        check("prog.loadb_daddr", oa_daddr, 32'h1B);
      end
      if (oa_state == 32'(S_ADD)) begin
        seen |= 2;
        check("prog.add_regs", {oa_ra[7:0], oa_rb[7:0], oa_wa[7:0], oa_alu[7:0]}, 32'h02040301);
      end
      if (oa_state == 32'(S_STORE)) begin
        seen |= 4;
        check("prog.store_daddr", oa_daddr, 32'hA5);
        check("prog.store_ra", oa_ra, 32'd3);
        check("prog.store_dwr", 32'(oa_dwr), 32'd1);
      end
    end
    check("prog.states_seen", 32'(seen), 32'd7);
    check("prog.halted", 32'(oa_halt), 32'd1);
    check("prog.halt_state", oa_state, 32'(S_HALT));
    check("prog.halt_pc", oa_pc, 32'd4);

    // Data-memory wait states: three low D_Ack cycles in STORE
    clear_rom();
    rom[0] = 16'h1A53; rom[1] = 16'h5000;
    do_reset();
    na = 0; st_cnt_a = 0; st_cnt_b = 0; wr_cnt_a = 0;
    for (int i = 0; i < 15; i++) begin
      bit ak = 1'b1;
      if (ma.st == S_STORE) begin ak = (na >= 3); na++; end
      tick(1'b1, 1'b1, 1'b0, ak, 1'b1);
      if (oa_state == 32'(S_STORE)) st_cnt_a++;
      if (oa_dwr) wr_cnt_a++;
      if (ob_state == 32'(S_STORE)) st_cnt_b++;
    end
    check("wait.store_cycles_hs", 32'(st_cnt_a), 32'd4);
    check("wait.dwr_cycles_hs", 32'(wr_cnt_a), 32'd4);
    check("wait.store_cycles_nohs", 32'(st_cnt_b), 32'd1);

    // Single step
    fill_rom_random(1'b0);
    do_reset();
    for (int i = 0; i < 21; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("step.idle_state", oa_state, 32'(S_FETCH));
    check("step.idle_pc", oa_pc, 32'd0);
    for (int p = 0; p < 5; p++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("step.pulse_state", oa_state, 32'(S_FETCH));
      check("step.pulse_pc", oa_pc, 32'(p + 1));
    end
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Illegal opcode at the top of the address space, then PC wrap
    clear_rom();
    rom[8'h7F] = 16'hF000;
    do_reset();
    saw_ill_noop = 1'b0; saw_wrap = 1'b0; prev_pc = 32'd0;
    for (int i = 0; i < 400; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      if (oa_state == 32'(S_NOOP) && oa_ir == 32'h0000F000) saw_ill_noop = 1'b1;
      if (prev_pc == 32'h7F && oa_pc == 32'd0) saw_wrap = 1'b1;
      prev_pc = oa_pc;
    end
    check("ill.flag_a", 32'(oa_ill), 32'd1);
    check("ill.flag_b", 32'(ob_ill), 32'd0);
    check("ill.via_noop", 32'(saw_ill_noop), 32'd1);
    check("ill.pc_wrap", 32'(saw_wrap), 32'd1);

    // Reset asserted during a STORE wait
    clear_rom();
    rom[0] = 16'h1A53;
    do_reset();
    for (int i = 0; i < 10 && ma.st != S_STORE; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst.state_during", oa_state, 32'(S_STORE));
    check("rst.dwr_during", 32'(oa_dwr), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst.state_after", oa_state, 32'(S_INIT));
    check("rst.pc_after", oa_pc, 32'd0);
    check("rst.ir_after", oa_ir, 32'd0);

    // Random programs, run/step/ack and occasional resets
    fill_rom_random(1'b1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r, rn, sp, ak;
      r  = ($urandom_range(0, 149) != 0);
      rn = ($urandom_range(0, 3) != 0);
      sp = $urandom_range(0, 1) == 1;
      ak = $urandom_range(0, 1) == 1;
      tick(r, rn, sp, ak, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the 16-bit processor. It fetches instructions from a synchronous instruction ROM, decodes them and sequences the register file, ALU and data-memory controls of the datapath. It adds three things: configurable PC width, a data-memory ready handshake, and run/single-step/halt modes. Debug outputs (IR, PC, state, next state) feed the processor top level.

## Interface
- PC_W, 7: program counter width; the PC wraps modulo 2^PC_W.
- RESET_PC, 0: PC value loaded on reset.
- D_AW, 8: data address width, 1..8; D_Addr takes the low D_AW bits of the instruction address field.
- DMEM_HS, 1: 1 = LOAD_A/STORE wait for D_Ack; 0 = fixed single cycle, D_Ack ignored.

Ports:
- Clk  in  1  processor clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Run  in  1  1 = free-run; 0 = pause in FETCH unless Step is high.
- Step  in  1  executes exactly one instruction when sampled high in FETCH while Run=0.
- IM_Addr  out  PC_W  instruction ROM address, equal to the PC.
- IM_Rd  out  1  ROM read enable, high in FETCH.
- IM_Data  in  16  ROM read data, valid the cycle after IM_Rd.
- D_Addr  out  D_AW  data memory address.
- D_Rd / D_Wr  out  1  data memory read / write strobes.
- D_Ack  in  1  data memory done (DMEM_HS=1 only).
- RF_s  out  1  RF write mux: 1 = memory data, 0 = ALU.
- RF_W_en  out  1  RF write enable.
- RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr  out  4  RF port addresses.
- ALU_s0  out  3  ALU select: 0 pass, 1 add, 2 sub.
- IR_Out  out  16  instruction register.
- PC_Out  out  PC_W  program counter.
- State, NextState  out  4  current and combinational next FSM state.
- Halted  out  1  high while in HALT.
- Illegal  out  1  sticky flag; set on an undefined opcode.

## Operation
- States: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9. Codes 10–15 are unreachable; if reached, next state is INIT.
- Opcode is IR[15:12]: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT. 0110–1111 are illegal: the instruction executes as NOOP and sets Illegal.
- All control outputs are 0 unless listed for a state.
- **INIT:** goes to FETCH.
- **FETCH:** IM_Rd=1.
  - Goes to DECODE if Run=1 or Step=1; otherwise stays in FETCH.
- **DECODE:** IR ← IM_Data and PC ← PC+1 (wrapping).
  - NextState is decoded from IM_Data[15:12], not from IR.
- **LOAD_A:** D_Addr=IR[7:0], D_Rd=1.
  - DMEM_HS=1: stays until D_Ack=1.
  - Then goes to LOAD_B.
- **LOAD_B:** D_Addr held at IR[7:0], RF_s=1, RF_W_en=1, RF_W_Addr=IR[11:8]; goes to FETCH.
- **STORE:** D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_Wr=1.
  - D_Wr stays high on every wait cycle.
  - Leaves to FETCH on D_Ack=1, or immediately if DMEM_HS=0.
- **ADD / SUB:** RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_W_en=1, RF_s=0.
  - ALU_s0 is 1 for ADD, 2 for SUB.
  - Goes to FETCH.
- **HALT:** Halted=1; stays in HALT until reset. Run and Step are ignored.
- D_Ack outside LOAD_A/STORE is ignored.

## Timing
- **Reset** (Reset=0 at a rising edge):
  - Register values: State=INIT, PC=RESET_PC, IR=0, Illegal=0.
  - Halted=0.
  - This applies mid-operation from any state, including a STORE wait.
- **While Reset=0:** D_Wr, D_Rd, RF_W_en are forced 0 combinationally and NextState=INIT.
- **First fetch:** the first FETCH is the second cycle after Reset returns high.
- **Cycles per instruction,** counted FETCH→next FETCH with Run=1 and zero waits:
  - NOOP/ADD/SUB/STORE: 3 cycles.
  - LOAD: 4 cycles.
  - Each cycle D_Ack is low in LOAD_A/STORE adds one cycle.
- **ROM:** IM_Addr must equal PC during FETCH. The ROM has one-cycle synchronous latency.
- **Illegal flag:** set at the DECODE→NOOP edge and cleared only by reset.
- **Single step:** a one-cycle Step pulse in FETCH with Run=0 runs one instruction, then holds in FETCH. If Step is held high, one instruction runs per FETCH visit.
- **PC wrap:** PC = 2^PC_W−1 increments to 0.

## Test plan
- **Reset and basic sequencing.** Reset low for 2 cycles, then high, ROM[0]=0x0000 (NOOP).
  - Required: State 0→1→2→3→1.
  - PC_Out=0 in the first FETCH and 1 in the next.
- **LOAD/ADD/STORE/HALT program.** ROM = 0x221B (LOAD R2←[0x1B]), 0x3243 (ADD R2+R4→R3), 0x1A53 (STORE [0xA5]←R3), 0x5000 (HALT); D_Ack=1.
  - LOAD_B: RF_W_Addr=2, RF_s=1.
  - ADD: Ra=2, Rb=4, W=3, ALU_s0=1.
  - STORE: D_Addr=0xA5, Ra=3, D_Wr=1.
  - Ends with Halted=1 and State=9, PC_Out=4.
- **Data-memory wait states.** DMEM_HS=1, D_Ack held low 3 cycles in STORE.
  - Required: D_Wr high for 4 cycles, STORE lasts 4 cycles, then FETCH.
  - With DMEM_HS=0, STORE lasts 1 cycle regardless of D_Ack.
- **Single step.** Run=0, one-cycle Step pulses.
  - Required: exactly one instruction per pulse.
  - Without a pulse, State stays at 1 and PC is unchanged for 20 cycles.
- **Illegal opcode and PC wrap.** ROM[0x7F]=0xF000, PC_W=7.
  - Required: Illegal=1, the instruction goes through the NOOP state, PC_Out wraps 0x7F→0x00.
- **Reset during a memory wait.** Reset=0 asserted mid-STORE with D_Ack=0.
  - Required: D_Wr=0 in the same cycle.
  - Next cycle: State=0, PC=RESET_PC, IR_Out=0.
